// File: rtl/pedo_weight_bank.sv
// Shadow/active weight register bank with commit FSM, registered readback and a saturating step counter.
// Optional write lock is built in when PEDO_WEIGHT_LOCK_EN is defined.
module pedo_weight_bank #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned RESET_VAL = 10,
  parameter int unsigned STEP_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef PEDO_WEIGHT_LOCK_EN
  input  logic                         lock,
  output logic                         locked,
`endif
  input  logic                         wr_en1,
  input  logic [ADDR_W-1:0]            wr_addr1,
  input  logic [DATA_W-1:0]            wr_data1,
  input  logic                         wr_en2,
  input  logic [ADDR_W-1:0]            wr_addr2,
  input  logic [DATA_W-1:0]            wr_data2,
  input  logic                         clear,
  input  logic                         commit,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic [NUM_REGS*DATA_W-1:0]   weights_flat,
  output logic                         commit_busy,
  output logic                         commit_done,
  output logic                         wr_err,
  input  logic                         step_inc,
  input  logic                         step_load,
  input  logic [STEP_W-1:0]            step_in,
  output logic [STEP_W-1:0]            total_steps,
  output logic                         steps_sat
);

  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
  localparam logic [DATA_W-1:0] RST_WORD   = DATA_W'(RESET_VAL);

  typedef enum logic {S_IDLE, S_COPY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                copy_en;
  logic                done_d;
  logic                err_d;
  logic                idle;
  logic                open;
  logic                lock_active;
  logic                any_req;
  logic                rng1, rng2, rng_rd;

  logic [DATA_W-1:0]   shadow [NUM_REGS];
  logic [DATA_W-1:0]   active [NUM_REGS];

`ifdef PEDO_WEIGHT_LOCK_EN
  logic locked_q;

  // Lock is sticky until reset; only armed from IDLE.
  always_ff @(posedge clk) begin
    if (reset)                      locked_q <= 1'b0;
    else if (lock && state_q == S_IDLE) locked_q <= 1'b1;
  end

  assign locked      = locked_q;
  assign lock_active = locked_q;
`else
  assign lock_active = 1'b0;
`endif

  assign idle    = (state_q == S_IDLE);
  assign open    = idle && !lock_active;
  assign any_req = wr_en1 || wr_en2 || clear || commit;
  assign rng1    = {1'b0, wr_addr1} < NUM_REGS_W;
  assign rng2    = {1'b0, wr_addr2} < NUM_REGS_W;
  assign rng_rd  = {1'b0, rd_addr}  < NUM_REGS_W;

  // Next-state, copy control and rejection detect.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    copy_en = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (commit && !lock_active) begin
          state_d = S_COPY;
          idx_d   = '0;
        end
        if (lock_active && any_req) err_d = 1'b1;
        if (open && ((wr_en1 && !rng1) || (wr_en2 && !rng2))) err_d = 1'b1;
      end
      S_COPY: begin
        copy_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
        if (any_req) err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      commit_busy <= 1'b0;
      commit_done <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      commit_busy <= (state_d == S_COPY);
      commit_done <= done_d;
      wr_err      <= err_d;
    end
  end

  // Shadow bank: clear wins, port 2 assigned last so it wins on address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) shadow[i] <= RST_WORD;
    end else if (open) begin
      if (clear) begin
        for (int i = 0; i < int'(NUM_REGS); i++) shadow[i] <= '0;
      end else begin
        if (wr_en1 && rng1) shadow[wr_addr1] <= wr_data1;
        if (wr_en2 && rng2) shadow[wr_addr2] <= wr_data2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) active[i] <= RST_WORD;
    end else if (copy_en) begin
      active[idx_q] <= shadow[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       rd_data <= '0;
    else if (rng_rd) rd_data <= active[rd_addr];
    else             rd_data <= '0;
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
    assign weights_flat[g*DATA_W +: DATA_W] = active[g];
  end

  // Load has priority and also clears the sticky saturation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      total_steps <= '0;
      steps_sat   <= 1'b0;
    end else if (step_load) begin
      total_steps <= step_in;
      steps_sat   <= 1'b0;
    end else if (step_inc) begin
      if (&total_steps) steps_sat   <= 1'b1;
      else              total_steps <= total_steps + STEP_W'(1);
    end
  end

endmodule

// File: tb/tb_pedo_weight_bank.sv
// Directed self-checking bench for pedo_weight_bank (default parameters).
module tb_pedo_weight_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en1, wr_en2, clear, commit;
  logic [2:0]  wr_addr1, wr_addr2, rd_addr;
  logic [7:0]  wr_data1, wr_data2, rd_data;
  logic [63:0] weights_flat;
  logic        commit_busy, commit_done, wr_err;
  logic        step_inc, step_load, steps_sat;
  logic [15:0] step_in, total_steps;
`ifdef PEDO_WEIGHT_LOCK_EN
  logic        lock, locked;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pedo_weight_bank dut (
    .clk(clk), .reset(reset),
`ifdef PEDO_WEIGHT_LOCK_EN
    .lock(lock), .locked(locked),
`endif
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .wr_en2(wr_en2), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
    .clear(clear), .commit(commit), .rd_addr(rd_addr), .rd_data(rd_data),
    .weights_flat(weights_flat), .commit_busy(commit_busy),
    .commit_done(commit_done), .wr_err(wr_err),
    .step_inc(step_inc), .step_load(step_load), .step_in(step_in),
    .total_steps(total_steps), .steps_sat(steps_sat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with commit_busy high; stops at a bound so a stuck FSM cannot hang the run.
  task automatic wait_commit(output int n);
    n = 0;
    while (commit_busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  int n;
  int done_seen;

  initial begin
    reset = 1'b1; wr_en1 = 0; wr_en2 = 0; clear = 0; commit = 0;
    wr_addr1 = 0; wr_addr2 = 0; wr_data1 = 0; wr_data2 = 0; rd_addr = 0;
    step_inc = 0; step_load = 0; step_in = 0;
`ifdef PEDO_WEIGHT_LOCK_EN
    lock = 0;
`endif
    tick();
    tick();
    check("reset_weights", weights_flat, 64'h0A0A0A0A0A0A0A0A);
    check("reset_steps", 64'(total_steps), 64'h0);
    check("reset_rd", 64'(rd_data), 64'h0);
    check("reset_flags", 64'({commit_busy, commit_done, wr_err, steps_sat}), 64'h0);
    reset = 1'b0;

    // Port collision on address 2 with commit in the same cycle: port 2 wins.
    wr_en1 = 1; wr_addr1 = 2; wr_data1 = 8'h33;
    wr_en2 = 1; wr_addr2 = 2; wr_data2 = 8'h44;
    commit = 1;
    tick();
    wr_en1 = 0; wr_en2 = 0; commit = 0;
    check("busy_rise", 64'(commit_busy), 64'h1);
    wait_commit(n);
    check("busy_len", 64'(n), 64'd8);
    check("done_pulse", 64'(commit_done), 64'h1);
    rd_addr = 2;
    tick();
    check("done_clear", 64'(commit_done), 64'h0);
    check("rd_collide", 64'(rd_data), 64'h44);
    check("weights_collide", weights_flat, 64'h0A0A0A0A0A440A0A);

    // Write landing with commit, then a write attempted during COPY.
    wr_en1 = 1; wr_addr1 = 5; wr_data1 = 8'h55; commit = 1;
    tick();
    commit = 0; wr_addr1 = 5; wr_data1 = 8'h99;
    tick();
    wr_en1 = 0;
    check("err_in_copy", 64'(wr_err), 64'h1);
    tick();
    check("err_pulse_end", 64'(wr_err), 64'h0);
    wait_commit(n);
    check("copy2_done", 64'(commit_done), 64'h1);
    check("weights_copy2", weights_flat, 64'h0A0A550A0A440A0A);
    commit = 1;
    tick();
    commit = 0;
    wait_commit(n);
    rd_addr = 5;
    tick();
    check("shadow_untouched", weights_flat, 64'h0A0A550A0A440A0A);
    check("rd_5", 64'(rd_data), 64'h55);

    // Clear beats a simultaneous write.
    clear = 1; wr_en1 = 1; wr_addr1 = 1; wr_data1 = 8'h77;
    tick();
    clear = 0; wr_en1 = 0; commit = 1;
    tick();
    commit = 0;
    wait_commit(n);
    rd_addr = 1;
    tick();
    check("clear_weights", weights_flat, 64'h0);
    check("clear_rd", 64'(rd_data), 64'h0);

    // Saturating step accumulator.
    step_load = 1; step_in = 16'hFFFE;
    tick();
    step_load = 0;
    check("step_load", 64'(total_steps), 64'hFFFE);
    step_inc = 1;
    tick();
    check("step_ffff", 64'({steps_sat, total_steps}), 64'h0FFFF);
    tick();
    check("step_sat", 64'({steps_sat, total_steps}), 64'h1FFFF);
    tick();
    check("step_hold", 64'({steps_sat, total_steps}), 64'h1FFFF);
    step_load = 1; step_in = 16'd5;
    tick();
    step_load = 0; step_inc = 0;
    check("step_reload", 64'({steps_sat, total_steps}), 64'h00005);

    // Reset in the middle of a commit.
    wr_en1 = 1; wr_addr1 = 0; wr_data1 = 8'h21; commit = 1;
    tick();
    wr_en1 = 0; commit = 0;
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    check("midreset_busy", 64'({commit_busy, commit_done}), 64'h0);
    check("midreset_weights", weights_flat, 64'h0A0A0A0A0A0A0A0A);
    check("midreset_steps", 64'(total_steps), 64'h0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (commit_done || commit_busy) done_seen++;
    end
    check("midreset_no_done", 64'(done_seen), 64'h0);

`ifdef PEDO_WEIGHT_LOCK_EN
    check("lock_reset", 64'(locked), 64'h0);
    lock = 1;
    tick();
    lock = 0;
    check("lock_set", 64'(locked), 64'h1);
    wr_en1 = 1; wr_addr1 = 0; wr_data1 = 8'h01; commit = 1;
    tick();
    wr_en1 = 0; commit = 0;
    check("lock_err", 64'({wr_err, commit_busy}), 64'h2);
    tick();
    tick();
    check("lock_weights", weights_flat, 64'h0A0A0A0A0A0A0A0A);
    step_inc = 1;
    tick();
    step_inc = 0;
    check("lock_steps", 64'(total_steps), 64'h1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
